// File: rtl/main_ctrl_pipe.sv
// Registered decode-stage main controller: opcode decode into the DE/EX control register,
// load-use bubble insertion, stall/flush and a saturating illegal-opcode counter. Jumps: MAIN_CTRL_JUMP_EN.
module main_ctrl_pipe #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int ILL_CNT_W        = 8,
    parameter int REG_AW           = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6:0]           opcode,
    input  logic [REG_AW-1:0]    rd,
    input  logic [REG_AW-1:0]    rs1,
    input  logic [REG_AW-1:0]    rs2,
    input  logic                 ex_ready,
    input  logic                 flush,
    output logic                 ex_valid,
    output logic [1:0]           ex_alu_op,
    output logic [1:0]           ex_alu_src2,
    output logic                 ex_brn_cond,
    output logic                 ex_mem_we,
    output logic                 ex_reg_we,
    output logic                 ex_mem_reg,
    output logic                 ex_jump,
    output logic [REG_AW-1:0]    ex_rd,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] ill_cnt
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef MAIN_CTRL_JUMP_EN
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
`endif
    localparam logic [1:0] BUB_EXTRA = 2'(LOAD_USE_BUBBLES - 1);

    typedef struct packed {
        logic [1:0]        alu_op;
        logic [1:0]        alu_src2;
        logic              brn_cond;
        logic              mem_we;
        logic              reg_we;
        logic              mem_reg;
        logic              jump;
        logic [REG_AW-1:0] rd;
    } ctrl_t;

    typedef enum logic {IDLE, BUBBLE} state_t;

    function automatic logic [ILL_CNT_W-1:0] sat_inc(input logic [ILL_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t                 state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    ctrl_t                  ex_q, ex_d, dec;
    logic                   ex_vld_q, ex_vld_d;
    logic                   illegal_q, illegal_d;
    logic [ILL_CNT_W-1:0]   ill_cnt_q, ill_cnt_d;
    logic                   dec_legal, use_rs1, use_rs2;
    logic                   hz, accept;

    always_comb begin
        dec       = '0;
        dec_legal = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        case (opcode)
            OP_R: begin
                dec.alu_op = 2'b10; dec.reg_we = 1'b1;
                dec_legal = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_I: begin
                dec.alu_src2 = 2'd1; dec.reg_we = 1'b1;
                dec_legal = 1'b1; use_rs1 = 1'b1;
            end
            OP_LOAD: begin
                dec.alu_src2 = 2'd1; dec.reg_we = 1'b1; dec.mem_reg = 1'b1;
                dec_legal = 1'b1; use_rs1 = 1'b1;
            end
            OP_STORE: begin
                dec.alu_src2 = 2'd2; dec.mem_we = 1'b1;
                dec_legal = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                dec.alu_op = 2'b01; dec.alu_src2 = 2'd3; dec.brn_cond = 1'b1;
                dec_legal = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
`ifdef MAIN_CTRL_JUMP_EN
            OP_JAL: begin
                dec.alu_src2 = 2'd1; dec.reg_we = 1'b1; dec.jump = 1'b1;
                dec_legal = 1'b1;
            end
            OP_JALR: begin
                dec.alu_src2 = 2'd1; dec.reg_we = 1'b1; dec.jump = 1'b1;
                dec_legal = 1'b1; use_rs1 = 1'b1;
            end
`endif
            default: ;
        endcase
        dec.rd = rd;
    end

    // A load in EX whose destination feeds a source of the incoming instruction; x0 never hazards.
    assign hz = in_valid && ex_vld_q && ex_q.mem_reg && (ex_q.rd != '0) &&
                ((use_rs1 && (ex_q.rd == rs1)) || (use_rs2 && (ex_q.rd == rs2)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ex_q      <= '0;
            ex_vld_q  <= 1'b0;
            illegal_q <= 1'b0;
            ill_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ex_q      <= ex_d;
            ex_vld_q  <= ex_vld_d;
            illegal_q <= illegal_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (ex_ready) begin
            case (state_q)
                IDLE: begin
                    if (hz && (BUB_EXTRA != 2'd0)) begin
                        cnt_d   = BUB_EXTRA;
                        state_d = BUBBLE;
                    end
                end
                BUBBLE: begin
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = !flush && ex_ready && (state_q == IDLE) && !hz;
        accept    = in_valid && in_ready;
        ex_d      = ex_q;
        ex_vld_d  = ex_vld_q;
        illegal_d = 1'b0;
        ill_cnt_d = ill_cnt_q;
        if (flush) begin
            ex_d     = '0;
            ex_vld_d = 1'b0;
        end else if (ex_ready) begin
            // Default on advance is a bubble; only a legal accepted instruction replaces it.
            ex_d     = '0;
            ex_vld_d = 1'b0;
            if (accept) begin
                if (dec_legal) begin
                    ex_d     = dec;
                    ex_vld_d = 1'b1;
                end else begin
                    illegal_d = 1'b1;
                    ill_cnt_d = sat_inc(ill_cnt_q);
                end
            end
        end
    end

    assign ex_valid    = ex_vld_q;
    assign ex_alu_op   = ex_q.alu_op;
    assign ex_alu_src2 = ex_q.alu_src2;
    assign ex_brn_cond = ex_q.brn_cond;
    assign ex_mem_we   = ex_q.mem_we;
    assign ex_reg_we   = ex_q.reg_we;
    assign ex_mem_reg  = ex_q.mem_reg;
    assign ex_jump     = ex_q.jump;
    assign ex_rd       = ex_q.rd;
    assign illegal     = illegal_q;
    assign ill_cnt     = ill_cnt_q;

endmodule

// File: tb/tb_main_ctrl_pipe.sv
// Scoreboard bench for main_ctrl_pipe with LOAD_USE_BUBBLES=2; follows MAIN_CTRL_JUMP_EN if defined.
module tb_main_ctrl_pipe;

    localparam int AW = 5;
    localparam int CW = 8;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, in_valid, in_ready, ex_ready, flush;
    logic [6:0]    opcode;
    logic [AW-1:0] rd, rs1, rs2, ex_rd;
    logic          ex_valid, ex_brn_cond, ex_mem_we, ex_reg_we, ex_mem_reg, ex_jump, illegal;
    logic [1:0]    ex_alu_op, ex_alu_src2;
    logic [CW-1:0] ill_cnt;

    main_ctrl_pipe #(.LOAD_USE_BUBBLES(2), .ILL_CNT_W(CW), .REG_AW(AW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .ex_ready(ex_ready), .flush(flush),
        .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_alu_src2(ex_alu_src2),
        .ex_brn_cond(ex_brn_cond), .ex_mem_we(ex_mem_we), .ex_reg_we(ex_reg_we),
        .ex_mem_reg(ex_mem_reg), .ex_jump(ex_jump), .ex_rd(ex_rd),
        .illegal(illegal), .ill_cnt(ill_cnt)
    );

    typedef struct packed {
        logic          vld;
        logic [1:0]    op;
        logic [1:0]    src;
        logic          brn, mwe, rwe, mreg, jmp;
        logic [AW-1:0] rd;
        logic          ill;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t decode_exp(input logic [6:0] opc, input logic [AW-1:0] rdv);
        exp_t e;
        e = '0;
        e.vld = 1'b1;
        e.rd  = rdv;
        case (opc)
            OP_R:      begin e.op = 2'b10; e.rwe = 1'b1; end
            OP_I:      begin e.src = 2'd1; e.rwe = 1'b1; end
            OP_LOAD:   begin e.src = 2'd1; e.rwe = 1'b1; e.mreg = 1'b1; end
            OP_STORE:  begin e.src = 2'd2; e.mwe = 1'b1; end
            OP_BRANCH: begin e.op = 2'b01; e.src = 2'd3; e.brn = 1'b1; end
`ifdef MAIN_CTRL_JUMP_EN
            OP_JAL, OP_JALR: begin e.src = 2'd1; e.rwe = 1'b1; e.jmp = 1'b1; end
`endif
            default: begin e = '0; e.ill = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic drive(input logic v, input logic [6:0] opc, input logic [AW-1:0] rdv,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        in_valid = v; opcode = opc; rd = rdv; rs1 = r1; rs2 = r2;
    endtask

    task automatic check_ready(input string nm, input logic exp);
        #1;
        checks++;
        if (in_ready !== exp) begin
            failures++;
            $display("FAIL %s: in_ready=%b expected %b", nm, in_ready, exp);
        end
    endtask

    task automatic step_cmp(input string nm);
        exp_t e, got;
        @(posedge clk);
        #1;
        got = {ex_valid, ex_alu_op, ex_alu_src2, ex_brn_cond, ex_mem_we, ex_reg_we,
               ex_mem_reg, ex_jump, ex_rd, illegal};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty, got %h", nm, got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                failures++;
                $display("FAIL %s: ex bundle got %h expected %h", nm, got, e);
            end
        end
    endtask

    task automatic check_cnt(input string nm, input logic [CW-1:0] exp);
        checks++;
        if (ill_cnt !== exp) begin
            failures++;
            $display("FAIL %s: ill_cnt=%0d expected %0d", nm, ill_cnt, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        drive(1'b1, OP_R, 5'd1, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back('0);
        checks++;
        if ({ex_valid, ex_alu_op, ex_alu_src2, ex_brn_cond, ex_mem_we, ex_reg_we,
             ex_mem_reg, ex_jump, ex_rd, illegal} !== exp_q.pop_front()) begin
            failures++;
            $display("FAIL reset_outputs: ex_valid=%b ex_rd=%0d illegal=%b", ex_valid, ex_rd, illegal);
        end
        check_cnt("reset_cnt", '0);
        reset = 1'b0;
        drive(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
        check_ready("reset_ready", 1'b1);
    endtask

    task automatic test_decode();
        logic [6:0] ops [5];
        ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LOAD; ops[3] = OP_STORE; ops[4] = OP_BRANCH;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ops[i], 5'(3 + i), 5'd0, 5'd0);
            check_ready("decode_ready", 1'b1);
            exp_q.push_back(decode_exp(ops[i], 5'(3 + i)));
            step_cmp("decode");
        end
        drive(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
        exp_q.push_back('0);
        step_cmp("idle_bubble");
    endtask

    task automatic test_load_use();
        drive(1'b1, OP_LOAD, 5'd5, 5'd0, 5'd0);
        exp_q.push_back(decode_exp(OP_LOAD, 5'd5));
        step_cmp("lu_load");
        drive(1'b1, OP_R, 5'd8, 5'd5, 5'd0);
        for (int i = 0; i < 2; i++) begin
            check_ready("lu_stall", 1'b0);
            exp_q.push_back('0);
            step_cmp("lu_bubble");
        end
        check_ready("lu_release", 1'b1);
        exp_q.push_back(decode_exp(OP_R, 5'd8));
        step_cmp("lu_r");
        // rs2 hazard through a store
        drive(1'b1, OP_LOAD, 5'd6, 5'd0, 5'd0);
        exp_q.push_back(decode_exp(OP_LOAD, 5'd6));
        step_cmp("lu2_load");
        drive(1'b1, OP_STORE, 5'd2, 5'd0, 5'd6);
        check_ready("lu2_stall", 1'b0);
        exp_q.push_back('0);
        step_cmp("lu2_b0");
        exp_q.push_back('0);
        step_cmp("lu2_b1");
        check_ready("lu2_release", 1'b1);
        exp_q.push_back(decode_exp(OP_STORE, 5'd2));
        step_cmp("lu2_store");
        // x0 destination never stalls
        drive(1'b1, OP_LOAD, 5'd0, 5'd0, 5'd0);
        exp_q.push_back(decode_exp(OP_LOAD, 5'd0));
        step_cmp("lu0_load");
        drive(1'b1, OP_R, 5'd9, 5'd0, 5'd0);
        check_ready("lu0_nostall", 1'b1);
        exp_q.push_back(decode_exp(OP_LOAD, 5'd7));
        drive(1'b1, OP_LOAD, 5'd7, 5'd0, 5'd0);
        step_cmp("lu0_load7");
        // I-type does not read rs2
        drive(1'b1, OP_I, 5'd10, 5'd0, 5'd7);
        check_ready("lu_irs2_nostall", 1'b1);
        exp_q.push_back(decode_exp(OP_I, 5'd10));
        step_cmp("lu_i");
    endtask

    task automatic test_stall();
        drive(1'b1, OP_STORE, 5'd4, 5'd1, 5'd2);
        exp_q.push_back(decode_exp(OP_STORE, 5'd4));
        step_cmp("st_store");
        ex_ready = 1'b0;
        drive(1'b1, OP_R, 5'd11, 5'd1, 5'd2);
        for (int i = 0; i < 3; i++) begin
            check_ready("st_ready", 1'b0);
            exp_q.push_back(decode_exp(OP_STORE, 5'd4));
            step_cmp("st_hold");
        end
        ex_ready = 1'b1;
        check_ready("st_release", 1'b1);
        exp_q.push_back(decode_exp(OP_R, 5'd11));
        step_cmp("st_r");
    endtask

    task automatic test_flush();
        drive(1'b1, OP_LOAD, 5'd9, 5'd0, 5'd0);
        exp_q.push_back(decode_exp(OP_LOAD, 5'd9));
        step_cmp("fl_load");
        drive(1'b1, OP_R, 5'd12, 5'd9, 5'd0);
        check_ready("fl_hz", 1'b0);
        exp_q.push_back('0);
        step_cmp("fl_bubble");
        flush = 1'b1;
        check_ready("fl_ready", 1'b0);
        exp_q.push_back('0);
        step_cmp("fl_kill");
        flush = 1'b0;
        ex_ready = 1'b0;
        check_ready("fl_idle_exr0", 1'b0);
        ex_ready = 1'b1;
        check_ready("fl_idle_exr1", 1'b1);
        exp_q.push_back(decode_exp(OP_R, 5'd12));
        step_cmp("fl_r");
        drive(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
        flush = 1'b1; ex_ready = 1'b0;
        exp_q.push_back('0);
        step_cmp("fl_noready");
        flush = 1'b0; ex_ready = 1'b1;
    endtask

    task automatic test_illegal();
        drive(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
        exp_q.push_back('0);
        step_cmp("il_idle");
        ex_ready = 1'b0;
        drive(1'b1, OP_BAD, 5'd1, 5'd0, 5'd0);
        check_ready("il_noaccept_ready", 1'b0);
        exp_q.push_back('0);
        step_cmp("il_noaccept");
        check_cnt("il_noaccept_cnt", '0);
        ex_ready = 1'b1; flush = 1'b1;
        exp_q.push_back('0);
        step_cmp("il_flushed");
        check_cnt("il_flushed_cnt", '0);
        flush = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            check_ready("il_ready", 1'b1);
            exp_q.push_back(decode_exp(OP_BAD, 5'd1));
            step_cmp("il_pulse");
            check_cnt("il_cnt", (i > 255) ? 8'd255 : 8'(i));
        end
        drive(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
        exp_q.push_back('0);
        step_cmp("il_pulse_end");
        check_cnt("il_sat", 8'd255);
    endtask

    task automatic test_jump();
        drive(1'b1, OP_JAL, 5'd1, 5'd0, 5'd0);
        check_ready("jal_ready", 1'b1);
`ifdef MAIN_CTRL_JUMP_EN
        exp_q.push_back(decode_exp(OP_JAL, 5'd1));
`else
        exp_q.push_back(exp_t'(1));
`endif
        step_cmp("jal");
        drive(1'b1, OP_JALR, 5'd2, 5'd3, 5'd0);
        check_ready("jalr_ready", 1'b1);
`ifdef MAIN_CTRL_JUMP_EN
        exp_q.push_back(decode_exp(OP_JALR, 5'd2));
`else
        exp_q.push_back(exp_t'(1));
`endif
        step_cmp("jalr");
        drive(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_decode();
        test_load_use();
        test_stall();
        test_flush();
        test_illegal();
        test_jump();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/main_ctrl_pipe.md
Name: main_ctrl_pipe

Overview:
Registered successor of the decode-stage main controller.
- Decodes the instruction's opcode into control bundles and registers them into the DE/EX control register with a valid/ready handshake.
- Detects load-use hazards and inserts a parametrisable number of bubbles.
- Handles stall and flush.
- Counts illegal opcodes.
- Sits between fetch/decode and the execute stage.

Parameters:
LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard; legal range 1..3
ILL_CNT_W, 8, width of the saturating illegal-opcode counter
REG_AW, 5, register address width

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  decode has an instruction
in_ready  out  1  instruction accepted this cycle (in_valid && in_ready)
opcode  in  7  instruction bits [6:0]
rd  in  REG_AW  destination register
rs1  in  REG_AW  source register 1
rs2  in  REG_AW  source register 2
ex_ready  in  1  execute stage can take a new bundle
flush  in  1  branch redirect; kills the EX bundle and any pending bubbles
ex_valid  out  1  EX bundle valid
ex_alu_op  out  2  2'b10 REG, 2'b00 IMM, 2'b01 BRANCH compare
ex_alu_src2  out  2  0 reg, 1 I-imm, 2 S-imm, 3 B-imm
ex_brn_cond  out  1  branch instruction
ex_mem_we  out  1  store
ex_reg_we  out  1  register writeback
ex_mem_reg  out  1  writeback from memory (load)
ex_jump  out  1  jump (see Optional Feature)
ex_rd  out  REG_AW  destination register carried to EX
illegal  out  1  one-cycle pulse: illegal opcode consumed last cycle
ill_cnt  out  ILL_CNT_W  saturating count of illegal opcodes

Behaviour:
Reset:
- All ex_* outputs are 0, illegal=0, ill_cnt=0, bubble counter=0, state IDLE.

Decode (combinational, registered on advance):
- R 0110011: op REG, src 0, reg_we.
- I 0010011: op IMM, src 1, reg_we.
- LOAD 0000011: op IMM, src 1, reg_we, mem_reg.
- STORE 0100011: op IMM, src 2, mem_we.
- BRANCH 1100011: op BRANCH, src 3, brn_cond.
- rs1 is used by all of the above. rs2 is used by R, STORE and BRANCH.

Advance:
- The EX register updates only when ex_ready=1. When ex_ready=0, all EX outputs, the counter and the state hold, and in_ready=0.

Bubble:
- ex_valid=0 and all control bits are 0. ex_rd=0.

Hazard:
- hz = in_valid && ex_valid && ex_mem_reg && ex_rd!=0 && (ex_rd==rs1 used || ex_rd==rs2 used).

State IDLE:
- in_ready = ex_ready && !hz.
- hz && ex_ready: insert a bubble. If LOAD_USE_BUBBLES>1, set cnt <= LOAD_USE_BUBBLES-1 and go to BUBBLE.
- Accepted instruction: load its decoded bundle into EX.
- Neither of the above (ex_ready && !in_valid): load a bubble.

State BUBBLE:
- in_ready=0. Each cycle with ex_ready, insert a bubble and decrement cnt.
- Go to IDLE when cnt reaches 0.

Flush:
- Highest priority after reset.
- Next cycle: ex_valid=0, cnt=0, state IDLE.
- in_ready=0 in the flush cycle, so no instruction is consumed.
- Takes effect regardless of ex_ready.

Illegal opcode (any opcode outside the set, including the jump opcodes when the feature is off):
- Consumed normally when in_ready=1, and loads a bubble.
- illegal=1 for the next cycle only.
- ill_cnt increments and saturates at all-ones.
- A flushed or non-accepted instruction does not count.

Latency:
- Accepted instruction at edge N gives its EX bundle valid after edge N.

Optional Feature:
Macro MAIN_CTRL_JUMP_EN.
- Defined:
  - JAL 1101111: reg_we, ex_jump=1, op IMM, src 1; uses no sources.
  - JALR 1100111: same as JAL, and uses rs1 for hazard checks.
- Undefined:
  - Both opcodes are illegal.
  - ex_jump is tied to 0.

Test Plan:
- Reset, then R opcode rd=3, in_valid, ex_ready=1 -> next cycle ex_valid=1, alu_op=2'b10, src=0, reg_we=1, ex_rd=3; all other control bits 0.
- LOAD rd=5, then R rs1=5, LOAD_USE_BUBBLES=2 -> in_ready=0 for 2 cycles, two bubbles in EX, R bundle appears on the 3rd cycle; LOAD rd=0 followed by rs1=0 -> no stall.
- ex_ready=0 for 3 cycles while a STORE sits in EX -> EX outputs unchanged, in_ready=0; release -> next instruction loads one cycle later.
- flush during BUBBLE with cnt=1 -> next cycle ex_valid=0, state IDLE, in_ready returns to ex_ready.
- Opcode 1111111 accepted 300 times with ILL_CNT_W=8 -> illegal pulses each time, ill_cnt=255, every EX slot a bubble.
- JAL rd=1: with MAIN_CTRL_JUMP_EN -> ex_jump=1, reg_we=1, src=1; without the macro -> illegal=1, ex_valid=0.
